// File: rtl/reorder_buffer_if.sv
// ============================================================================
// Module   : reorder_buffer_if
// Brief    : Scheduler <-> reorder buffer bundle (alloc, CDB, lookup, commit)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reorder_buffer_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              flush;
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_has_dest;
    logic              alloc_ready;
    logic [DATA_W-1:0] alloc_value;
    logic              alloc_accept;
    logic [31:0]       rob_tail;
    logic [31:0]       rob_count;
    logic              rob_full;
    logic [31:0]       cdb1_tag;
    logic [DATA_W-1:0] cdb1_value;
    logic [31:0]       cdb2_tag;
    logic [DATA_W-1:0] cdb2_value;
    logic [31:0]       lookup_tag_1;
    logic [31:0]       lookup_tag_2;
    logic              lookup_ready_1;
    logic              lookup_ready_2;
    logic [DATA_W-1:0] lookup_value_1;
    logic [DATA_W-1:0] lookup_value_2;
    logic              commit_stall;
    logic              commit_valid;
    logic [31:0]       commit_tag;
    logic [REG_W-1:0]  commit_rd;
    logic              commit_has_dest;
    logic [DATA_W-1:0] commit_value;

    modport master (
        output flush, alloc_valid, alloc_rd, alloc_has_dest, alloc_ready, alloc_value,
        input  alloc_accept, rob_tail, rob_count, rob_full,
        output cdb1_tag, cdb1_value, cdb2_tag, cdb2_value,
        output lookup_tag_1, lookup_tag_2,
        input  lookup_ready_1, lookup_ready_2, lookup_value_1, lookup_value_2,
        output commit_stall,
        input  commit_valid, commit_tag, commit_rd, commit_has_dest, commit_value
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_has_dest, alloc_ready, alloc_value,
        output alloc_accept, rob_tail, rob_count, rob_full,
        input  cdb1_tag, cdb1_value, cdb2_tag, cdb2_value,
        input  lookup_tag_1, lookup_tag_2,
        output lookup_ready_1, lookup_ready_2, lookup_value_1, lookup_value_2,
        input  commit_stall,
        output commit_valid, commit_tag, commit_rd, commit_has_dest, commit_value
    );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Brief    : Circular ROB: in-order alloc, dual CDB capture, in-order commit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic           clk,
    input  logic           reset,
    reorder_buffer_if.slave bus
);
    localparam int c_IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL   = c_CNT_W'(ROB_SIZE);
    localparam logic [31:0]        c_MAXTAG = 32'(ROB_SIZE);

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [REG_W-1:0]    r_rd       [ROB_SIZE];
    logic                r_has_dest [ROB_SIZE];
    logic [DATA_W-1:0]   r_value    [ROB_SIZE];
    logic [c_IDX_W-1:0]  r_head;
    logic [c_IDX_W-1:0]  r_tail;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_CNT_W-1:0]  w_count_nxt;

    logic               w_full;
    logic               w_accept;
    logic               w_commit;
    logic [c_IDX_W-1:0] w_cdb1_idx;
    logic [c_IDX_W-1:0] w_cdb2_idx;
    logic [c_IDX_W-1:0] w_lk1_idx;
    logic [c_IDX_W-1:0] w_lk2_idx;
    logic               w_cdb1_hit;
    logic               w_cdb2_hit;
    logic               w_lk1_hit;
    logic               w_lk2_hit;

    // Tag t addresses index t-1; tag 0 and out-of-range tags address nothing.
    assign w_cdb1_idx = c_IDX_W'(bus.cdb1_tag - 32'd1);
    assign w_cdb2_idx = c_IDX_W'(bus.cdb2_tag - 32'd1);
    assign w_lk1_idx  = c_IDX_W'(bus.lookup_tag_1 - 32'd1);
    assign w_lk2_idx  = c_IDX_W'(bus.lookup_tag_2 - 32'd1);

    assign w_cdb1_hit = (bus.cdb1_tag != 32'd0) && (bus.cdb1_tag <= c_MAXTAG) && r_busy[w_cdb1_idx];
    assign w_cdb2_hit = (bus.cdb2_tag != 32'd0) && (bus.cdb2_tag <= c_MAXTAG) && r_busy[w_cdb2_idx];
    assign w_lk1_hit  = (bus.lookup_tag_1 != 32'd0) && (bus.lookup_tag_1 <= c_MAXTAG) && r_busy[w_lk1_idx];
    assign w_lk2_hit  = (bus.lookup_tag_2 != 32'd0) && (bus.lookup_tag_2 <= c_MAXTAG) && r_busy[w_lk2_idx];

    assign w_full   = (r_count == c_FULL);
    assign w_accept = bus.alloc_valid && !w_full && !bus.flush;
    assign w_commit = (r_count != '0) && r_busy[r_head] && r_ready[r_head]
                      && !bus.commit_stall && !bus.flush;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_accept, w_commit})
            2'b10:   w_count_nxt = r_count + c_CNT_W'(1);
            2'b01:   w_count_nxt = r_count - c_CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (bus.flush) begin
            r_busy  <= '0;
            r_ready <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cdb2_hit) r_ready[w_cdb2_idx] <= 1'b1;
            if (w_cdb1_hit) r_ready[w_cdb1_idx] <= 1'b1;
            if (w_accept) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= bus.alloc_ready;
                r_tail          <= r_tail + c_IDX_W'(1);
            end
            if (w_commit) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + c_IDX_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Payload is only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_cdb2_hit) r_value[w_cdb2_idx] <= bus.cdb2_value;
        if (w_cdb1_hit) r_value[w_cdb1_idx] <= bus.cdb1_value;
        if (w_accept) begin
            r_value[r_tail]    <= bus.alloc_value;
            r_rd[r_tail]       <= bus.alloc_rd;
            r_has_dest[r_tail] <= bus.alloc_has_dest;
        end
    end

    assign bus.alloc_accept = w_accept;
    assign bus.rob_tail     = 32'(r_tail) + 32'd1;
    assign bus.rob_count    = 32'(r_count);
    assign bus.rob_full     = w_full;

    assign bus.lookup_ready_1 = w_lk1_hit && r_ready[w_lk1_idx];
    assign bus.lookup_ready_2 = w_lk2_hit && r_ready[w_lk2_idx];
    assign bus.lookup_value_1 = w_lk1_hit ? r_value[w_lk1_idx] : '0;
    assign bus.lookup_value_2 = w_lk2_hit ? r_value[w_lk2_idx] : '0;

    assign bus.commit_valid    = w_commit;
    assign bus.commit_tag      = w_commit ? (32'(r_head) + 32'd1) : 32'd0;
    assign bus.commit_rd       = w_commit ? r_rd[r_head] : '0;
    assign bus.commit_has_dest = w_commit && r_has_dest[r_head];
    assign bus.commit_value    = w_commit ? r_value[r_head] : '0;
endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module   : tb_reorder_buffer
// Brief    : Directed self-checking bench for reorder_buffer (ROB_SIZE=16)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reorder_buffer_if #(.DATA_W(32), .REG_W(5)) bus ();

    reorder_buffer #(.ROB_SIZE(16), .DATA_W(32), .REG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_set(input logic v, input logic [4:0] rd, input logic hd,
                             input logic rdy, input logic [31:0] val);
        bus.alloc_valid    = v;
        bus.alloc_rd       = rd;
        bus.alloc_has_dest = hd;
        bus.alloc_ready    = rdy;
        bus.alloc_value    = val;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.flush = 1'b0;
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.cdb1_tag = 0; bus.cdb1_value = 0;
        bus.cdb2_tag = 0; bus.cdb2_value = 0;
        bus.lookup_tag_1 = 32'd1; bus.lookup_tag_2 = 32'd0;
        bus.commit_stall = 1'b0;
        step(); step();

        chk("rst_tail",   bus.rob_tail, 1);
        chk("rst_count",  bus.rob_count, 0);
        chk("rst_full",   bus.rob_full, 0);
        chk("rst_accept", bus.alloc_accept, 0);
        chk("rst_cvalid", bus.commit_valid, 0);
        chk("rst_ctag",   bus.commit_tag, 0);
        chk("rst_lkrdy",  bus.lookup_ready_1, 0);
        chk("rst_lkval",  bus.lookup_value_1, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // three pending allocations rd=5,6,7
        for (int i = 0; i < 3; i++) begin
            alloc_set(1'b1, 5'(5 + i), 1'b1, 1'b0, 32'h75 + 32'(i));
            #1;
            chk("a3_accept", bus.alloc_accept, 1);
            chk("a3_tail",   bus.rob_tail, 64'(1 + i));
            step();
        end
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("a3_tail_end", bus.rob_tail, 4);
        chk("a3_count",    bus.rob_count, 3);
        chk("a3_cvalid",   bus.commit_valid, 0);
        bus.lookup_tag_1 = 32'd3;
        #1;
        chk("lk3_busy_rdy", bus.lookup_ready_1, 0);
        chk("lk3_busy_val", bus.lookup_value_1, 32'h77);

        // out-of-order completion: tag2 first, head must wait
        bus.cdb1_tag = 32'd2; bus.cdb1_value = 32'hAA;
        #1;
        chk("cdb2_cvalid_same", bus.commit_valid, 0);
        step();
        bus.cdb1_tag = 0;
        bus.lookup_tag_1 = 32'd2; bus.lookup_tag_2 = 32'd1;
        #1;
        chk("head_not_ready", bus.commit_valid, 0);
        chk("lk2_rdy", bus.lookup_ready_1, 1);
        chk("lk2_val", bus.lookup_value_1, 32'hAA);
        chk("lk1_rdy", bus.lookup_ready_2, 0);
        chk("lk1_val", bus.lookup_value_2, 32'h75);
        bus.cdb2_tag = 32'd1; bus.cdb2_value = 32'h11;
        #1;
        chk("no_bypass", bus.commit_valid, 0);
        step();
        bus.cdb2_tag = 0;
        #1;
        chk("c1_valid", bus.commit_valid, 1);
        chk("c1_tag",   bus.commit_tag, 1);
        chk("c1_rd",    bus.commit_rd, 5);
        chk("c1_hd",    bus.commit_has_dest, 1);
        chk("c1_val",   bus.commit_value, 32'h11);
        step();
        chk("c2_valid", bus.commit_valid, 1);
        chk("c2_tag",   bus.commit_tag, 2);
        chk("c2_rd",    bus.commit_rd, 6);
        chk("c2_val",   bus.commit_value, 32'hAA);
        step();
        chk("c2_after_valid", bus.commit_valid, 0);
        chk("c2_after_count", bus.rob_count, 1);

        // same tag on both CDBs: cdb1 wins
        bus.cdb1_tag = 32'd3; bus.cdb1_value = 32'h33;
        bus.cdb2_tag = 32'd3; bus.cdb2_value = 32'h44;
        step();
        bus.cdb1_tag = 0; bus.cdb2_tag = 0;
        bus.lookup_tag_1 = 32'd3; bus.lookup_tag_2 = 32'd3;
        #1;
        chk("dual_lk_rdy",  bus.lookup_ready_1, 1);
        chk("dual_lk_val",  bus.lookup_value_1, 32'h33);
        chk("dual_lk2_val", bus.lookup_value_2, 32'h33);
        chk("c3_tag",       bus.commit_tag, 3);
        chk("c3_val",       bus.commit_value, 32'h33);
        step();
        chk("empty_count", bus.rob_count, 0);
        chk("empty_tail",  bus.rob_tail, 4);

        // pre-completed entry (ecall), then stall
        alloc_set(1'b1, 5'd0, 1'b0, 1'b1, 32'hEC);
        #1;
        chk("ec_accept", bus.alloc_accept, 1);
        chk("ec_cvalid_same", bus.commit_valid, 0);
        step();
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("ec_cvalid", bus.commit_valid, 1);
        chk("ec_hd",     bus.commit_has_dest, 0);
        chk("ec_tag",    bus.commit_tag, 4);
        chk("ec_val",    bus.commit_value, 32'hEC);
        bus.commit_stall = 1'b1;
        #1;
        chk("stall_cvalid", bus.commit_valid, 0);
        chk("stall_ctag",   bus.commit_tag, 0);
        step();
        chk("stall_count1", bus.rob_count, 1);
        step();
        chk("stall_count2", bus.rob_count, 1);
        bus.commit_stall = 1'b0;
        #1;
        chk("unstall_cvalid", bus.commit_valid, 1);
        step();
        chk("unstall_count", bus.rob_count, 0);

        // fill all 16 (pre-completed, retirement stalled)
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.commit_stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_set(1'b1, 5'(i), 1'b1, 1'b1, 32'h100 + 32'(i));
            #1;
            chk("fill_accept", bus.alloc_accept, 1);
            step();
        end
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("full_flag",  bus.rob_full, 1);
        chk("full_count", bus.rob_count, 16);
        chk("full_tail",  bus.rob_tail, 1);
        alloc_set(1'b1, 5'd9, 1'b1, 1'b1, 32'h999);
        #1;
        chk("full_refuse", bus.alloc_accept, 0);
        step();
        chk("full_count_hold", bus.rob_count, 16);
        bus.commit_stall = 1'b0;
        #1;
        chk("full_commit_refuse", bus.alloc_accept, 0);
        chk("full_commit_tag",    bus.commit_tag, 1);
        chk("full_commit_val",    bus.commit_value, 32'h100);
        step();
        chk("after_full_count", bus.rob_count, 15);
        chk("after_full_flag",  bus.rob_full, 0);
        chk("simul_accept",     bus.alloc_accept, 1);
        chk("simul_ctag",       bus.commit_tag, 2);
        chk("simul_cval",       bus.commit_value, 32'h101);
        step();
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.commit_stall = 1'b1;
        bus.lookup_tag_1 = 32'd1;
        #1;
        chk("simul_count", bus.rob_count, 15);
        chk("wrap_tail",   bus.rob_tail, 2);
        chk("wrap_lk_rdy", bus.lookup_ready_1, 1);
        chk("wrap_lk_val", bus.lookup_value_1, 32'h999);

        // flush with count=5 plus same-cycle alloc and CDB
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.commit_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            alloc_set(1'b1, 5'(i + 1), 1'b1, 1'b0, 32'(i));
            step();
        end
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("pre_flush_count", bus.rob_count, 5);
        chk("pre_flush_tail",  bus.rob_tail, 6);
        bus.flush = 1'b1;
        alloc_set(1'b1, 5'd3, 1'b1, 1'b0, 32'h3);
        bus.cdb1_tag = 32'd2; bus.cdb1_value = 32'h55;
        #1;
        chk("flush_accept", bus.alloc_accept, 0);
        chk("flush_cvalid", bus.commit_valid, 0);
        step();
        bus.flush = 1'b0;
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.cdb1_tag = 0;
        bus.lookup_tag_1 = 32'd2;
        #1;
        chk("flush_count",  bus.rob_count, 0);
        chk("flush_tail",   bus.rob_tail, 1);
        chk("flush_lk_rdy", bus.lookup_ready_1, 0);
        chk("flush_lk_val", bus.lookup_value_1, 0);

        // asynchronous reset mid-operation
        bus.commit_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            alloc_set(1'b1, 5'(20 + i), 1'b1, 1'b1, 32'hD0 + 32'(i));
            step();
        end
        alloc_set(1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
        bus.commit_stall = 1'b0;
        bus.lookup_tag_1 = 32'd1;
        #1;
        chk("prerst_cvalid", bus.commit_valid, 1);
        chk("prerst_cval",   bus.commit_value, 32'hD0);
        chk("prerst_tail",   bus.rob_tail, 3);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_cvalid", bus.commit_valid, 0);
        chk("arst_ctag",   bus.commit_tag, 0);
        chk("arst_crd",    bus.commit_rd, 0);
        chk("arst_cval",   bus.commit_value, 0);
        chk("arst_count",  bus.rob_count, 0);
        chk("arst_tail",   bus.rob_tail, 1);
        chk("arst_lkrdy",  bus.lookup_ready_1, 0);
        chk("arst_lkval",  bus.lookup_value_1, 0);
        @(negedge clk);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
